// File: rtl/ob_trace_pkg.sv
// ob_trace shared types: capture FSM states and trigger modes.
// Optional timestamp storage is enabled by defining OB_TRACE_TS_EN.
package ob_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    M_EQ  = 2'd0,
    M_NE  = 2'd1,
    M_IMM = 2'd2,
    M_CHG = 2'd3
  } mode_e;

  localparam int TSW = 16;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ob_trace_ram.sv
// ob_trace sample store: one write port, registered read port.
// Contents are never reset; readers only trust them after a capture.
module ob_trace_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ob_trace.sv
// ob_trace: multi-channel triggered trace buffer with pre-trigger history.
// Define OB_TRACE_TS_EN to store a 16-bit cycle stamp with every sample.
module ob_trace
  import ob_trace_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int PRE   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NCH*DW-1:0]              ch_data_i,
  input  logic                           ch_valid_i,
  input  logic                           arm_i,
  input  logic [clog2_min1(NCH)-1:0]     trig_ch_i,
  input  logic [DW-1:0]                  trig_val_i,
  input  logic [1:0]                     trig_mode_i,
  input  logic [$clog2(DEPTH)-1:0]       rd_addr_i,
  input  logic [$clog2(NCH+1)-1:0]       rd_ch_i,
  output logic [DW-1:0]                  rd_data_o,
  output logic [1:0]                     state_o,
  output logic                           done_o,
  output logic [$clog2(DEPTH)-1:0]       trig_idx_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int TCW = clog2_min1(NCH);
  localparam int RCW = $clog2(NCH+1);
  localparam logic [AW-1:0] PRE_A = AW'(PRE);
  localparam logic [AW-1:0] POST0 = AW'(DEPTH-PRE-1);
`ifdef OB_TRACE_TS_EN
  localparam int RW = NCH*DW + TSW;
`else
  localparam int RW = NCH*DW;
`endif

  state_e          state, state_n;
  logic [AW-1:0]   wptr, wptr_n;
  logic [AW-1:0]   fill, fill_n;
  logic [AW-1:0]   post, post_n;
  logic [AW-1:0]   tptr, tptr_n;
  logic [DW-1:0]   prev, prev_n;
  logic            hist, hist_n;
  logic [DW-1:0]   cur;
  logic            hit;
  logic            we;
  logic [RW-1:0]   wdata;
  logic [RW-1:0]   rdata;
  logic [AW-1:0]   raddr;
  logic            rd_ok;
  logic [RCW-1:0]  rd_ch_q;

  always_comb begin
    cur = '0;
    for (int c = 0; c < NCH; c++)
      if (trig_ch_i == TCW'(c)) cur = ch_data_i[c*DW +: DW];
  end

  always_comb begin
    hit = 1'b0;
    unique case (mode_e'(trig_mode_i))
      M_EQ:  hit = (cur == trig_val_i);
      M_NE:  hit = (cur != trig_val_i);
      M_IMM: hit = 1'b1;
      M_CHG: hit = hist && (cur != prev);
    endcase
  end

  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    fill_n  = fill;
    post_n  = post;
    tptr_n  = tptr;
    prev_n  = prev;
    hist_n  = hist;
    we      = 1'b0;
    // Re-arm has priority over any sample arriving in the same cycle.
    if (arm_i) begin
      state_n = ARMED;
      fill_n  = '0;
      post_n  = '0;
      hist_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: ;
        ARMED, CAPTURE: begin
          if (ch_valid_i) begin
            we     = 1'b1;
            wptr_n = wptr + 1'b1;
            prev_n = cur;
            hist_n = 1'b1;
            if (state == ARMED) begin
              if (fill == PRE_A && hit) begin
                tptr_n  = wptr;
                post_n  = POST0;
                state_n = (POST0 == '0) ? DONE : CAPTURE;
              end else if (fill != PRE_A) begin
                fill_n = fill + 1'b1;
              end
            end else begin
              post_n = post - 1'b1;
              if (post == AW'(1)) state_n = DONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wptr  <= '0;
      fill  <= '0;
      post  <= '0;
      tptr  <= '0;
      prev  <= '0;
      hist  <= 1'b0;
    end else begin
      state <= state_n;
      wptr  <= wptr_n;
      fill  <= fill_n;
      post  <= post_n;
      tptr  <= tptr_n;
      prev  <= prev_n;
      hist  <= hist_n;
    end
  end

`ifdef OB_TRACE_TS_EN
  logic [TSW-1:0] ts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts <= '0;
    else      ts <= ts + 16'd1;
  end

  assign wdata = {ts, ch_data_i};
`else
  assign wdata = ch_data_i;
`endif

  // Logical index 0 is the oldest kept sample, PRE slots before the trigger.
  assign raddr = tptr - PRE_A + rd_addr_i;

  ob_trace_ram #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ok   <= 1'b0;
      rd_ch_q <= '0;
    end else begin
      rd_ok   <= (state == DONE);
      rd_ch_q <= rd_ch_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_ok) begin
      for (int c = 0; c < NCH; c++)
        if (rd_ch_q == RCW'(c)) rd_data_o = rdata[c*DW +: DW];
`ifdef OB_TRACE_TS_EN
      if (rd_ch_q == RCW'(NCH)) rd_data_o = DW'(rdata[RW-1 -: TSW]);
`endif
    end
  end

  assign state_o    = state;
  assign done_o     = (state == DONE);
  assign trig_idx_o = (state == DONE) ? PRE_A : '0;

endmodule

// File: tb/tb_ob_trace.sv
// Directed + randomized bench for ob_trace against a sample-list model.
// Build with OB_TRACE_TS_EN defined to also cover the timestamp channel.
module tb_ob_trace;

  localparam int DW    = 32;
  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int AW    = 4;
  localparam int POSTN = DEPTH - PRE - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH*DW-1:0] ch_data_i = '0;
  logic              ch_valid_i = 1'b0;
  logic              arm_i = 1'b0;
  logic [1:0]        trig_ch_i = '0;
  logic [DW-1:0]     trig_val_i = '0;
  logic [1:0]        trig_mode_i = '0;
  logic [AW-1:0]     rd_addr_i = '0;
  logic [2:0]        rd_ch_i = '0;
  logic [DW-1:0]     rd_data_o;
  logic [1:0]        state_o;
  logic              done_o;
  logic [AW-1:0]     trig_idx_o;

  int checks = 0;
  int errors = 0;

  int                m_state = 0;
  int                m_trigk = 0;
  logic [NCH*DW-1:0] smp [$];

  ob_trace #(
    .DW(DW), .NCH(NCH), .DEPTH(DEPTH), .PRE(PRE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_data_i   (ch_data_i),
    .ch_valid_i  (ch_valid_i),
    .arm_i       (arm_i),
    .trig_ch_i   (trig_ch_i),
    .trig_val_i  (trig_val_i),
    .trig_mode_i (trig_mode_i),
    .rd_addr_i   (rd_addr_i),
    .rd_ch_i     (rd_ch_i),
    .rd_data_o   (rd_data_o),
    .state_o     (state_o),
    .done_o      (done_o),
    .trig_idx_o  (trig_idx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] chv(input logic [NCH*DW-1:0] s,
                                         input int c);
    return s[c*DW +: DW];
  endfunction

  function automatic logic [NCH*DW-1:0] mk(input int ch, input logic [DW-1:0] v);
    logic [NCH*DW-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*DW +: DW] = $urandom;
    d[ch*DW +: DW] = v;
    return d;
  endfunction

  // Model: list of samples since the last arm; trigger index decides all.
  task automatic model_step(input logic a, input logic v,
                            input logic [NCH*DW-1:0] d);
    int  k;
    logic hit;
    if (a) begin
      m_state = 1;
      smp.delete();
    end else if (v && (m_state == 1 || m_state == 2)) begin
      smp.push_back(d);
      k = smp.size() - 1;
      if (m_state == 1) begin
        case (trig_mode_i)
          2'd0:    hit = chv(d, int'(trig_ch_i)) == trig_val_i;
          2'd1:    hit = chv(d, int'(trig_ch_i)) != trig_val_i;
          2'd2:    hit = 1'b1;
          default: hit = (k > 0) &&
                         chv(d, int'(trig_ch_i)) != chv(smp[k-1], int'(trig_ch_i));
        endcase
        if (k >= PRE && hit) begin
          m_trigk = k;
          m_state = (POSTN == 0) ? 3 : 2;
        end
      end else if (k == m_trigk + POSTN) begin
        m_state = 3;
      end
    end
  endtask

  task automatic cycle(input logic a, input logic v, input logic [NCH*DW-1:0] d);
    arm_i = a;
    ch_valid_i = v;
    ch_data_i = d;
    @(posedge clk);
    model_step(a, v, d);
    #1;
    check("state", 64'(state_o), 64'(m_state));
    check("done", 64'(done_o), 64'(m_state == 3));
    check("trig_idx", 64'(trig_idx_o), 64'((m_state == 3) ? PRE : 0));
    arm_i = 1'b0;
    ch_valid_i = 1'b0;
  endtask

  task automatic read_exp(input string tag, input int a, input int c,
                          input logic [DW-1:0] exp);
    rd_addr_i = a[AW-1:0];
    rd_ch_i = c[2:0];
    @(posedge clk);
    #1;
    check(tag, 64'(rd_data_o), 64'(exp));
  endtask

  task automatic read_all();
    logic [DW-1:0] exp;
    for (int a = 0; a < DEPTH; a++) begin
      for (int c = 0; c < NCH + 2; c++) begin
`ifdef OB_TRACE_TS_EN
        if (c == NCH) continue;
`endif
        exp = '0;
        if (m_state == 3 && c < NCH) exp = chv(smp[m_trigk - PRE + a], c);
        read_exp("rd_model", a, c, exp);
      end
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_rd", 64'(rd_data_o), 64'd0);
    check("rst_tidx", 64'(trig_idx_o), 64'd0);
    m_state = 0;
    smp.delete();
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    int first_done;
    int v;
    logic vld;
    logic [NCH*DW-1:0] d;

    #12;
    check("init_state", 64'(state_o), 64'd0);
    check("init_done", 64'(done_o), 64'd0);
    check("init_rd", 64'(rd_data_o), 64'd0);
    check("init_tidx", 64'(trig_idx_o), 64'd0);
    @(negedge clk) rst = 1'b1;

    // Valid samples while idle are ignored.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, mk(0, 7));

    // Equal trigger on a ramp.
    trig_mode_i = 2'd0; trig_ch_i = 2'd0; trig_val_i = 32'd10;
    cycle(1'b1, 1'b0, '0);
    first_done = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b1, mk(0, i));
      if (done_o && first_done < 0) first_done = i;
    end
    check("eq_done_at", 64'(first_done), 64'd21);
    read_exp("eq_a0", 0, 0, 6);
    read_exp("eq_a4", 4, 0, 10);
    read_exp("eq_a15", 15, 0, 21);
    read_exp("eq_tsch", 3, NCH, 0);
    read_all();

    // Early match suppressed until the pre-trigger history is full.
    trig_val_i = 32'd2;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, mk(0, i));
    check("early_armed", 64'(state_o), 64'd1);
    read_exp("early_rd0", 4, 0, 0);
    trig_val_i = 32'd20;
    for (int i = 15; i < 45; i++) cycle(1'b0, 1'b1, mk(0, i));
    read_exp("late_a4", 4, 0, 20);
    read_all();

    // Change mode on channel 1.
    trig_mode_i = 2'd3; trig_ch_i = 2'd1;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, mk(1, 5));
    cycle(1'b0, 1'b1, mk(1, 9));
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, mk(1, $urandom));
    read_exp("chg_a3", 3, 1, 5);
    read_exp("chg_a4", 4, 1, 9);
    read_all();

    // Wrap: long pre-trigger history with gaps in the valid strobe.
    trig_mode_i = 2'd0; trig_ch_i = 2'd0; trig_val_i = 32'd40;
    cycle(1'b1, 1'b0, '0);
    v = 0;
    for (int c = 0; c < 300 && v < 60; c++) begin
      vld = ($urandom_range(0, 3) != 0);
      cycle(1'b0, vld, mk(0, v));
      if (vld) v++;
    end
    read_exp("wrap_a0", 0, 0, 36);
    read_exp("wrap_a15", 15, 0, 51);
    read_all();

    // Randomized runs with small data alphabet and occasional re-arm.
    for (int r = 0; r < 6; r++) begin
      trig_mode_i = 2'($urandom_range(0, 3));
      trig_ch_i = 2'($urandom_range(0, NCH - 1));
      trig_val_i = $urandom_range(0, 2);
      cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < 90; i++) begin
        for (int c = 0; c < NCH; c++) d[c*DW +: DW] = $urandom_range(0, 2);
        cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), d);
      end
      read_all();
    end

    // Async reset mid-capture.
    trig_mode_i = 2'd2;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < PRE + 3; i++) cycle(1'b0, 1'b1, mk(0, i));
    check("pre_rst_cap", 64'(state_o), 64'd2);
    do_reset();

    // Async reset from DONE clears the read port at once.
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b1, mk(0, 100 + i));
    read_exp("imm_a0", 0, 0, 100);
    do_reset();

    // Arm during capture, arm beating a trigger, arm from DONE.
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < PRE + 2; i++) cycle(1'b0, 1'b1, mk(0, i));
    cycle(1'b1, 1'b1, mk(0, 50));
    check("rearm_cap", 64'(state_o), 64'd1);
    for (int i = 0; i < PRE; i++) cycle(1'b0, 1'b1, mk(0, 60 + i));
    cycle(1'b1, 1'b1, mk(0, 70));
    check("arm_wins", 64'(state_o), 64'd1);
    for (int i = 0; i < DEPTH + 3; i++) cycle(1'b0, 1'b1, mk(0, 80 + i));
    read_all();
    cycle(1'b1, 1'b0, '0);
    check("rearm_done", 64'(state_o), 64'd1);

`ifdef OB_TRACE_TS_EN
    begin
      logic [DW-1:0] prev_ts;
      cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < DEPTH + 4; i++) cycle(1'b0, 1'b1, mk(0, i));
      read_exp("ts_done", 0, NCH + 1, 0);
      rd_addr_i = '0; rd_ch_i = 3'(NCH);
      @(posedge clk); #1;
      prev_ts = rd_data_o;
      for (int a = 1; a < DEPTH; a++) begin
        rd_addr_i = a[AW-1:0];
        @(posedge clk); #1;
        check("ts_inc", 64'(rd_data_o), 64'(DW'(prev_ts[15:0] + 16'd1)));
        prev_ts = rd_data_o;
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ob_trace.md
OB_TRACE -- requirements
Module: ob_trace

Interface
REQ-001 SHALL have parameter DW, default 32, meaning channel data width.
REQ-002 SHALL have parameter NCH, default 4, meaning number of traced channels (>=1).
REQ-003 SHALL have parameter DEPTH, default 16, meaning samples per channel (power of 2, >=4).
REQ-004 SHALL have parameter PRE, default 4, meaning pre-trigger samples kept (0..DEPTH-1).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst  in  1  async reset, active low.
REQ-006 SHALL have ports:
- ch_data_i  in  NCH*DW  packed channel samples, channel 0 in LSBs
- ch_valid_i  in  1  sample strobe
- arm_i  in  1  arm/re-arm pulse
- trig_ch_i  in  clog2(NCH) (min 1)  trigger channel
- trig_val_i  in  DW  trigger compare value
- trig_mode_i  in  2  00 equal, 01 not-equal, 10 immediate, 11 change
- rd_addr_i  in  clog2(DEPTH)  logical index, 0 = oldest
- rd_ch_i  in  clog2(NCH+1)  read channel
- rd_data_o  out  DW  read data
- state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- done_o  out  1  capture complete
- trig_idx_o  out  clog2(DEPTH)  logical index of trigger sample

Function
REQ-007 SHALL, in IDLE, ignore ch_valid_i; arm_i moves to ARMED next cycle.
REQ-008 SHALL, in ARMED and CAPTURE, write all channels at write pointer on each ch_valid_i cycle, pointer incrementing modulo DEPTH.
REQ-009 SHALL, in ARMED, saturate a fill counter at PRE; trigger qualified only when fill counter == PRE at the valid sample.
REQ-010 SHALL evaluate trigger on channel trig_ch_i of the current valid sample: equal/not-equal vs trig_val_i; immediate = always true; change = differs from previous valid sample on that channel, first sample after arm never matches.
REQ-011 SHALL, on qualified trigger, store that sample, record its physical pointer, go to CAPTURE with post counter = DEPTH-PRE-1.
REQ-012 SHALL, in CAPTURE, decrement post counter per valid sample; after the sample making it 0 (or immediately when DEPTH-PRE-1 == 0) go to DONE.
REQ-013 SHALL assert done_o exactly when state is DONE; no writes in DONE.
REQ-014 SHALL, on arm_i in any non-IDLE state, return to ARMED with fill/post counters and change-history cleared; arm_i wins over a simultaneous trigger.
REQ-015 SHALL map rd_addr_i to physical (trig_ptr - PRE + rd_addr_i) mod DEPTH.
REQ-016 SHALL register rd_data_o one cycle after rd_addr_i/rd_ch_i; 0 when state was not DONE or rd_ch_i out of range.
REQ-017 SHALL drive trig_idx_o = PRE in DONE, 0 otherwise.

Reset
REQ-018 SHALL, on rst low, immediately force IDLE, done_o=0, rd_data_o=0, trig_idx_o=0, pointers and counters 0, including mid-CAPTURE; buffer contents need not be cleared.

Configuration
REQ-019 SHALL, with OB_TRACE_TS_EN defined, keep a 16-bit free-running cycle counter (reset 0, wraps) stored per sample and returned when rd_ch_i == NCH.
REQ-020 SHALL, without OB_TRACE_TS_EN, omit the counter and storage; rd_ch_i == NCH returns 0.

Structure
REQ-021 SHALL place state enum and trigger-mode enum in package ob_trace_pkg.
REQ-022 SHALL use one sub-module ob_trace_ram: single write port, registered read port, parametrised width/depth.

Verification (NCH=4, DW=32, DEPTH=16, PRE=4)
REQ-023 SHALL check equal trigger: ch0 ramp 0,1,2.. every cycle, trig_val=10 -> DONE after sample 21; rd ch0 addr 0..15 = 6..21, trig_idx_o=4.
REQ-024 SHALL check early-trigger suppression: trig_val=2, ramp from 0 -> stays ARMED; trig_val=20 later -> addr 4 = 20.
REQ-025 SHALL check change mode: ch1 = 5 for 8 samples then 9 -> trigger; addr 3 = 5, addr 4 = 9.
REQ-026 SHALL check wrap: 40 samples before trigger at value 40 -> addr 0..15 = 36..51.
REQ-027 SHALL check reset mid-CAPTURE: rst low -> state_o=0, done_o=0 same cycle; arm_i during CAPTURE -> ARMED.
REQ-028 SHALL check OB_TRACE_TS_EN: valid every cycle from arm -> ch NCH readback strictly increments by 1 across addr 0..15.
